// File: rtl/regset_initiator_if.sv
// rtl/regset_initiator_if.sv - command, response and register-set bus bundle for regset_initiator
//
// Signals:
//   cmd_valid/cmd_ready        command handshake (initiator drives cmd_ready)
//   cmd_op                     00 write, 01 read, 10 copy, 11 swap
//   cmd_addr_a/cmd_addr_b      primary/secondary address
//   cmd_data                   write data (op 00)
//   rsp_valid/rsp_data         one-cycle response pulse and its data
//   rs_enable/rs_rw            register-set strobe and direction (1 = write)
//   rs_address/rs_wdata        register-set address and write data
//   rs_rdata                   register-set read data
// Modports: master = initiator side, slave = command source / register set side.

interface regset_initiator_if #(
  parameter int N = 4
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [2:0]   cmd_addr_a;
  logic [2:0]   cmd_addr_b;
  logic [N-1:0] cmd_data;
  logic         rsp_valid;
  logic [N-1:0] rsp_data;
  logic         rs_enable;
  logic         rs_rw;
  logic [2:0]   rs_address;
  logic [N-1:0] rs_wdata;
  logic [N-1:0] rs_rdata;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_data, rs_rdata,
    output cmd_ready, rsp_valid, rsp_data, rs_enable, rs_rw, rs_address, rs_wdata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_data, rs_rdata,
    input  cmd_ready, rsp_valid, rsp_data, rs_enable, rs_rw, rs_address, rs_wdata
  );
endinterface

// File: rtl/regset_initiator.sv
// rtl/regset_initiator.sv - command-driven bus initiator for an 8-entry register set
//
// Executes write, read, copy (A to B) and swap (A with B) commands against a
// register set that samples on the falling clock edge, returning one response
// per command.
//
// Ports:
//   clk_i   system clock; all state updates on the rising edge
//   rst_i   asynchronous active-high reset
//   bus     regset_initiator_if.master (command, response and register-set pins)

module regset_initiator #(
  parameter int N = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  regset_initiator_if.master bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC1 = 3'd1,
    ACC2 = 3'd2,
    ACC3 = 3'd3,
    RESP = 3'd4
  } state_e;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;

  state_e       state_q,      state_d;
  logic [1:0]   op_q,         op_d;
  logic [2:0]   addr_a_q,     addr_a_d;
  logic [2:0]   addr_b_q,     addr_b_d;
  logic [N-1:0] data_q,       data_d;
  logic [N-1:0] ta_q,         ta_d;
  logic         rs_enable_q,  rs_enable_d;
  logic         rs_rw_q,      rs_rw_d;
  logic [2:0]   rs_address_q, rs_address_d;
  logic [N-1:0] rs_wdata_q,   rs_wdata_d;
  logic         rsp_valid_q,  rsp_valid_d;
  logic [N-1:0] rsp_data_q,   rsp_data_d;

  logic cmd_ready;
  logic accept;

  // Ready drops as soon as reset rises so no command can be taken while the
  // block is being cleared.
  assign cmd_ready = (state_q == IDLE) && !rst_i;
  assign accept    = bus.cmd_valid && cmd_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      op_q         <= 2'b00;
      addr_a_q     <= 3'd0;
      addr_b_q     <= 3'd0;
      data_q       <= '0;
      ta_q         <= '0;
      rs_enable_q  <= 1'b0;
      rs_rw_q      <= 1'b0;
      rs_address_q <= 3'd0;
      rs_wdata_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_a_q     <= addr_a_d;
      addr_b_q     <= addr_b_d;
      data_q       <= data_d;
      ta_q         <= ta_d;
      rs_enable_q  <= rs_enable_d;
      rs_rw_q      <= rs_rw_d;
      rs_address_q <= rs_address_d;
      rs_wdata_q   <= rs_wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_a_d     = addr_a_q;
    addr_b_d     = addr_b_q;
    data_d       = data_q;
    ta_d         = ta_q;
    // Enable and the response strobe are single-cycle pulses: they fall
    // unless this edge issues a new access / response.
    rs_enable_d  = 1'b0;
    rs_rw_d      = rs_rw_q;
    rs_address_d = rs_address_q;
    rs_wdata_d   = rs_wdata_q;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d         = bus.cmd_op;
          addr_a_d     = bus.cmd_addr_a;
          addr_b_d     = bus.cmd_addr_b;
          data_d       = bus.cmd_data;
          rs_enable_d  = 1'b1;
          rs_address_d = bus.cmd_addr_a;
          if (bus.cmd_op == OP_WRITE) begin
            rs_rw_d    = 1'b1;
            rs_wdata_d = bus.cmd_data;
          end else begin
            // Read, copy and swap all start by reading A.
            rs_rw_d    = 1'b0;
          end
          if (bus.cmd_op == OP_WRITE || bus.cmd_op == OP_READ) begin
            state_d = RESP;
          end else begin
            state_d = ACC1;
          end
        end
      end

      ACC1: begin
        // Read data for A is on the bus now; keep it for the response and,
        // for a swap, for the final write to B.
        ta_d         = bus.rs_rdata;
        rs_enable_d  = 1'b1;
        rs_address_d = addr_b_q;
        if (op_q == OP_COPY) begin
          rs_rw_d    = 1'b1;
          rs_wdata_d = bus.rs_rdata;
          state_d    = RESP;
        end else begin
          rs_rw_d    = 1'b0;
          state_d    = ACC2;
        end
      end

      ACC2: begin
        // Swap: old B (just read) goes into A.
        rs_enable_d  = 1'b1;
        rs_rw_d      = 1'b1;
        rs_address_d = addr_a_q;
        rs_wdata_d   = bus.rs_rdata;
        state_d      = ACC3;
      end

      ACC3: begin
        // Swap: old A (held in TA) goes into B.
        rs_enable_d  = 1'b1;
        rs_rw_d      = 1'b1;
        rs_address_d = addr_b_q;
        rs_wdata_d   = ta_q;
        state_d      = RESP;
      end

      RESP: begin
        rsp_valid_d = 1'b1;
        case (op_q)
          OP_WRITE: rsp_data_d = data_q;
          OP_READ:  rsp_data_d = bus.rs_rdata;
          default:  rsp_data_d = ta_q;
        endcase
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.rs_enable  = rs_enable_q;
  assign bus.rs_rw      = rs_rw_q;
  assign bus.rs_address = rs_address_q;
  assign bus.rs_wdata   = rs_wdata_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;

endmodule
